// File: rtl/tcb_lib_register_response_pipe_pkg.sv
// Shared types and limits for the TCB register response pipe.
// The tracking entry carries the transfer flag, the read flag and the byte enables.
package tcb_lib_register_response_pipe_pkg;

  localparam int unsigned DLY_MAX = 4;
  localparam int unsigned RSP_MAX = 4;
  localparam int unsigned BEW_MAX = 16;

  typedef struct packed {
    logic               trn;
    logic               ren;
    logic [BEW_MAX-1:0] ben;
  } trk_t;

  // A byte loads when the full word is taken, or when any byte in its hold group is read.
  function automatic logic [BEW_MAX-1:0] grp_load_mask(
    input trk_t        trk,
    input int unsigned bew,
    input int unsigned grn,
    input logic        hld
  );
    logic [BEW_MAX-1:0] msk;
    msk = '0;
    for (int unsigned i = 0; i < BEW_MAX; i++) begin
      if (i < bew) begin
        if (hld == 1'b0) begin
          msk[i] = trk.trn;
        end else begin
          for (int unsigned j = 0; j < BEW_MAX; j++) begin
            if ((j < bew) && ((j / grn) == (i / grn)) && trk.ben[j] && trk.ren && trk.trn) begin
              msk[i] = 1'b1;
            end else begin
              msk[i] = msk[i];
            end
          end
        end
      end else begin
        msk[i] = 1'b0;
      end
    end
    return msk;
  endfunction

endpackage

// File: rtl/tcb_lib_register_response_pipe_if.sv
// TCB bus bundle: request from manager to subordinate, response back.
interface tcb_lib_register_response_pipe_if #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned BEW = 4
);

  logic           vld;
  logic           wen;
  logic [ABW-1:0] adr;
  logic [BEW-1:0] ben;
  logic [DBW-1:0] wdt;
  logic           rdy;
  logic [DBW-1:0] rdt;
  logic           err;

  modport master (
    output vld, wen, adr, ben, wdt,
    input  rdy, rdt, err
  );

  modport slave (
    input  vld, wen, adr, ben, wdt,
    output rdy, rdt, err
  );

endinterface

// File: rtl/tcb_lib_register_response_pipe_stage.sv
// One response register stage: byte-group enabled data, pulse-style err, tracking entry.
module tcb_lib_register_response_pipe_stage
  import tcb_lib_register_response_pipe_pkg::*;
#(
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8,
  parameter int unsigned BEW = DBW/SLW,
  parameter int unsigned GRN = 1,
  parameter int unsigned HLD = 1
)(
  input  logic           clk,
  input  logic           rst,
  input  trk_t           trk_i,
  input  logic [DBW-1:0] rdt_i,
  input  logic           err_i,
  output trk_t           trk_o,
  output logic [DBW-1:0] rdt_o,
  output logic           err_o
);

  logic [BEW_MAX-1:0] ld_s;
  logic [DBW-1:0]     rdt_d;
  logic [DBW-1:0]     rdt_q;
  logic               err_d;
  logic               err_q;
  trk_t               trk_q;

  // Per-byte load enables derived from the incoming tracking entry.
  always_comb begin
    ld_s = grp_load_mask(trk_i, BEW, GRN, (HLD != 0));
  end

  if (BEW < BEW_MAX) begin : g_pad
    logic unused_ld_s;
    assign unused_ld_s = ^ld_s[BEW_MAX-1:BEW];
  end

  // Next data: selected byte lanes take new data, the rest hold.
  always_comb begin
    rdt_d = rdt_q;
    for (int unsigned b = 0; b < BEW; b++) begin
      if (ld_s[b]) begin
        rdt_d[b*SLW +: SLW] = rdt_i[b*SLW +: SLW];
      end else begin
        rdt_d[b*SLW +: SLW] = rdt_q[b*SLW +: SLW];
      end
    end
  end

  // err follows every tracked transfer and is cleared otherwise.
  always_comb begin
    if (trk_i.trn) begin
      err_d = err_i;
    end else begin
      err_d = 1'b0;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdt_q <= '0;
      err_q <= 1'b0;
      trk_q <= '0;
    end else begin
      rdt_q <= rdt_d;
      err_q <= err_d;
      trk_q <= trk_i;
    end
  end

  assign trk_o = trk_q;
  assign rdt_o = rdt_q;
  assign err_o = err_q;

endmodule

// File: rtl/tcb_lib_register_response_pipe.sv
// TCB response retiming pipe: request passes through, response is delayed by RSP
// register stages with byte-group hold, qualified by a DLY-deep tracking line.
module tcb_lib_register_response_pipe
  import tcb_lib_register_response_pipe_pkg::*;
#(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8,
  parameter int unsigned BEW = DBW/SLW,
  parameter int unsigned DLY = 1,
  parameter int unsigned RSP = 1,
  parameter int unsigned GRN = 1,
  parameter int unsigned HLD = 1
)(
  input  logic clk,
  input  logic rst,
  tcb_lib_register_response_pipe_if.slave  sub,
  tcb_lib_register_response_pipe_if.master man
);

  if ((RSP < 1) || (RSP > RSP_MAX)) begin : g_err_rsp
    $error("RSP must be in 1..RSP_MAX");
  end
  if (DLY > DLY_MAX) begin : g_err_dly
    $error("DLY must be in 0..DLY_MAX");
  end
  if ((GRN < 1) || ((BEW % GRN) != 0)) begin : g_err_grn
    $error("GRN must divide BEW");
  end
  if ((BEW > BEW_MAX) || ((BEW * SLW) != DBW) || (ABW < 1)) begin : g_err_bus
    $error("inconsistent bus widths");
  end

  assign man.vld = sub.vld;
  assign man.wen = sub.wen;
  assign man.adr = sub.adr;
  assign man.ben = sub.ben;
  assign man.wdt = sub.wdt;
  assign sub.rdy = man.rdy;

  trk_t trk_cur_s;
  trk_t trk_tap_s;

  // Tracking entry for the request on the bus this cycle.
  always_comb begin
    trk_cur_s     = '0;
    trk_cur_s.trn = sub.vld & man.rdy;
    trk_cur_s.ren = ~sub.wen;
    trk_cur_s.ben = BEW_MAX'(sub.ben);
  end

  if (DLY == 0) begin : g_nodly
    assign trk_tap_s = trk_cur_s;
  end else begin : g_dly
    trk_t trk_q [DLY];

    // Tracking delay line, aligned with the downstream response latency.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(DLY); i++) begin
          trk_q[i] <= '0;
        end
      end else begin
        trk_q[0] <= trk_cur_s;
        for (int i = 1; i < int'(DLY); i++) begin
          trk_q[i] <= trk_q[i-1];
        end
      end
    end

    assign trk_tap_s = trk_q[DLY-1];
  end

  trk_t           trk_s [RSP+1];
  logic [DBW-1:0] rdt_s [RSP+1];
  logic           err_s [RSP+1];

  assign trk_s[0] = trk_tap_s;
  assign rdt_s[0] = man.rdt;
  assign err_s[0] = man.err;

  for (genvar k = 0; k < RSP; k++) begin : g_stg
    tcb_lib_register_response_pipe_stage #(
      .DBW (DBW),
      .SLW (SLW),
      .BEW (BEW),
      .GRN (GRN),
      .HLD (HLD)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .trk_i (trk_s[k]),
      .rdt_i (rdt_s[k]),
      .err_i (err_s[k]),
      .trk_o (trk_s[k+1]),
      .rdt_o (rdt_s[k+1]),
      .err_o (err_s[k+1])
    );
  end

  logic unused_trk_s;
  assign unused_trk_s = ^trk_s[RSP];

  assign sub.rdt = rdt_s[RSP];
  assign sub.err = err_s[RSP];

endmodule

// File: tb/tb_tcb_lib_register_response_pipe.sv
// Directed bench: DLY=1, RSP=2, HLD=1 with GRN=1 (dut1) and GRN=2 (dut2) sharing stimulus.
module tb_tcb_lib_register_response_pipe;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic err_inj;
  logic [31:0] mem [64];

  always #5 clk = ~clk;

  tcb_lib_register_response_pipe_if #(.ABW(32), .DBW(32), .BEW(4)) sub1 (), man1 (), sub2 (), man2 ();

  tcb_lib_register_response_pipe #(.ABW(32), .DBW(32), .SLW(8), .BEW(4), .DLY(1), .RSP(2), .GRN(1), .HLD(1))
    dut1 (.clk(clk), .rst(rst), .sub(sub1), .man(man1));
  tcb_lib_register_response_pipe #(.ABW(32), .DBW(32), .SLW(8), .BEW(4), .DLY(1), .RSP(2), .GRN(2), .HLD(1))
    dut2 (.clk(clk), .rst(rst), .sub(sub2), .man(man2));

  assign sub2.vld = sub1.vld;
  assign sub2.wen = sub1.wen;
  assign sub2.adr = sub1.adr;
  assign sub2.ben = sub1.ben;
  assign sub2.wdt = sub1.wdt;
  assign man2.rdy = man1.rdy;
  assign man2.rdt = man1.rdt;
  assign man2.err = man1.err;

  // Downstream memory with one cycle of response delay; idle cycles drive junk.
  always @(posedge clk) begin
    if (!rst && man1.vld && man1.rdy) begin
      if (man1.wen) begin
        for (int b = 0; b < 4; b++) begin
          if (man1.ben[b]) mem[man1.adr[7:2]][b*8 +: 8] <= man1.wdt[b*8 +: 8];
        end
      end
      man1.rdt <= mem[man1.adr[7:2]];
      man1.err <= err_inj;
    end else begin
      man1.rdt <= 32'hDEAD_BEEF;
      man1.err <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic wen, input logic [31:0] adr, input logic [3:0] ben, input logic [31:0] wdt);
    sub1.vld = 1'b1; sub1.wen = wen; sub1.adr = adr; sub1.ben = ben; sub1.wdt = wdt;
    step();
    sub1.vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; err_inj = 1'b0; man1.rdy = 1'b1;
    sub1.vld = 1'b0; sub1.wen = 1'b0; sub1.adr = 32'h0; sub1.ben = 4'h0; sub1.wdt = 32'h0;
    step(); step();
    if (sub1.rdt !== 32'h0) begin $display("FAIL reset_rdt: got %h want %h", sub1.rdt, 32'h0); n_fail++; end
    n_checks++;
    if (sub1.err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", sub1.err); n_fail++; end
    n_checks++;
    if (sub2.rdt !== 32'h0) begin $display("FAIL reset_rdt2: got %h want %h", sub2.rdt, 32'h0); n_fail++; end
    n_checks++;
    sub1.vld = 1'b1; sub1.wen = 1'b1; sub1.adr = 32'h3C; sub1.ben = 4'h5; sub1.wdt = 32'hCAFE_F00D;
    #1;
    if ({man1.vld, man1.wen, man1.adr, man1.ben, man1.wdt} !== {1'b1, 1'b1, 32'h3C, 4'h5, 32'hCAFE_F00D}) begin
      $display("FAIL pass_req: got %b %b %h %h %h", man1.vld, man1.wen, man1.adr, man1.ben, man1.wdt); n_fail++;
    end
    n_checks++;
    if (sub1.rdy !== 1'b1) begin $display("FAIL pass_rdy1: got %b want 1", sub1.rdy); n_fail++; end
    n_checks++;
    man1.rdy = 1'b0;
    #1;
    if (sub1.rdy !== 1'b0) begin $display("FAIL pass_rdy0: got %b want 0", sub1.rdy); n_fail++; end
    n_checks++;
    man1.rdy = 1'b1; sub1.vld = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    xfer(1'b1, 32'h10, 4'hF, 32'h0123_4567);
    step(); step();
    if (sub1.rdt !== 32'h0) begin $display("FAIL wr_rsp_rdt: got %h want %h", sub1.rdt, 32'h0); n_fail++; end
    n_checks++;
    if (sub1.err !== 1'b0) begin $display("FAIL wr_rsp_err: got %b want 0", sub1.err); n_fail++; end
    n_checks++;
    xfer(1'b0, 32'h10, 4'hF, 32'h0);
    step();
    if (sub1.rdt !== 32'h0) begin $display("FAIL rd_early: got %h want %h", sub1.rdt, 32'h0); n_fail++; end
    n_checks++;
    step();
    if (sub1.rdt !== 32'h0123_4567) begin $display("FAIL rd_data: got %h want %h", sub1.rdt, 32'h0123_4567); n_fail++; end
    n_checks++;
    if (sub1.err !== 1'b0) begin $display("FAIL rd_err: got %b want 0", sub1.err); n_fail++; end
    n_checks++;
    step();
    if (sub1.rdt !== 32'h0123_4567) begin $display("FAIL rd_hold: got %h want %h", sub1.rdt, 32'h0123_4567); n_fail++; end
    n_checks++;
  endtask

  task automatic test_byte_hold();
    xfer(1'b1, 32'h24, 4'hF, 32'hFFFF_FFFF); step(); step();
    xfer(1'b1, 32'h20, 4'hF, 32'h1234_5678); step(); step();
    xfer(1'b0, 32'h24, 4'hF, 32'h0); step(); step();
    if (sub1.rdt !== 32'hFFFF_FFFF) begin $display("FAIL hold_pre: got %h want %h", sub1.rdt, 32'hFFFF_FFFF); n_fail++; end
    n_checks++;
    xfer(1'b0, 32'h20, 4'h3, 32'h0); step(); step();
    if (sub1.rdt !== 32'hFFFF_5678) begin $display("FAIL hold_ben3: got %h want %h", sub1.rdt, 32'hFFFF_5678); n_fail++; end
    n_checks++;
    if (sub2.rdt !== 32'hFFFF_5678) begin $display("FAIL hold_ben3_g2: got %h want %h", sub2.rdt, 32'hFFFF_5678); n_fail++; end
    n_checks++;
    xfer(1'b0, 32'h24, 4'hF, 32'h0); step(); step();
    xfer(1'b0, 32'h20, 4'h1, 32'h0); step(); step();
    if (sub1.rdt !== 32'hFFFF_FF78) begin $display("FAIL hold_ben1: got %h want %h", sub1.rdt, 32'hFFFF_FF78); n_fail++; end
    n_checks++;
    if (sub2.rdt !== 32'hFFFF_5678) begin $display("FAIL hold_ben1_g2: got %h want %h", sub2.rdt, 32'hFFFF_5678); n_fail++; end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v [4];
    exp_v = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
    for (int i = 0; i < 4; i++) begin
      sub1.vld = 1'b1; sub1.wen = 1'b1; sub1.adr = 32'(i * 4); sub1.ben = 4'hF; sub1.wdt = exp_v[i];
      step();
    end
    sub1.vld = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        if (sub1.rdt !== 32'hFFFF_FF78) begin $display("FAIL b2b_pre: got %h want %h", sub1.rdt, 32'hFFFF_FF78); n_fail++; end
        n_checks++;
      end
      if (i >= 3) begin
        if (sub1.rdt !== exp_v[i-3]) begin $display("FAIL b2b_rd%0d: got %h want %h", i - 3, sub1.rdt, exp_v[i-3]); n_fail++; end
        n_checks++;
      end
      if (i < 4) begin
        sub1.vld = 1'b1; sub1.wen = 1'b0; sub1.adr = 32'(i * 4); sub1.ben = 4'hF;
      end else begin
        sub1.vld = 1'b0;
      end
      step();
    end
    if (sub1.err !== 1'b0) begin $display("FAIL b2b_err: got %b want 0", sub1.err); n_fail++; end
    n_checks++;
  endtask

  task automatic test_error();
    err_inj = 1'b1;
    xfer(1'b0, 32'h0, 4'hF, 32'h0);
    err_inj = 1'b0;
    step();
    if (sub1.err !== 1'b0) begin $display("FAIL err_early: got %b want 0", sub1.err); n_fail++; end
    n_checks++;
    step();
    if (sub1.err !== 1'b1) begin $display("FAIL err_pulse: got %b want 1", sub1.err); n_fail++; end
    n_checks++;
    if (sub1.rdt !== 32'h0000_00A0) begin $display("FAIL err_rdt: got %h want %h", sub1.rdt, 32'h0000_00A0); n_fail++; end
    n_checks++;
    step();
    if (sub1.err !== 1'b0) begin $display("FAIL err_clear: got %b want 0", sub1.err); n_fail++; end
    n_checks++;
  endtask

  task automatic test_stall();
    man1.rdy = 1'b0;
    sub1.vld = 1'b1; sub1.wen = 1'b0; sub1.adr = 32'hC; sub1.ben = 4'hF;
    #1;
    if (sub1.rdy !== 1'b0) begin $display("FAIL stall_rdy: got %b want 0", sub1.rdy); n_fail++; end
    n_checks++;
    step();
    step();
    if (sub1.rdt !== 32'h0000_00A0) begin $display("FAIL stall_hold: got %h want %h", sub1.rdt, 32'h0000_00A0); n_fail++; end
    n_checks++;
    if (sub1.err !== 1'b0) begin $display("FAIL stall_err: got %b want 0", sub1.err); n_fail++; end
    n_checks++;
    man1.rdy = 1'b1;
    step();
    sub1.vld = 1'b0;
    step();
    if (sub1.rdt !== 32'h0000_00A0) begin $display("FAIL stall_t2: got %h want %h", sub1.rdt, 32'h0000_00A0); n_fail++; end
    n_checks++;
    step();
    if (sub1.rdt !== 32'h0000_00A3) begin $display("FAIL stall_rsp: got %h want %h", sub1.rdt, 32'h0000_00A3); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_inflight();
    xfer(1'b0, 32'h4, 4'hF, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    if (sub1.rdt !== 32'h0) begin $display("FAIL rst_rdt: got %h want %h", sub1.rdt, 32'h0); n_fail++; end
    n_checks++;
    if (sub1.err !== 1'b0) begin $display("FAIL rst_err: got %b want 0", sub1.err); n_fail++; end
    n_checks++;
    if (sub2.rdt !== 32'h0) begin $display("FAIL rst_rdt2: got %h want %h", sub2.rdt, 32'h0); n_fail++; end
    n_checks++;
    #1;
    rst = 1'b0;
    for (int i = 2; i < 5; i++) begin
      step();
      if (sub1.rdt !== 32'h0 || sub1.err !== 1'b0) begin
        $display("FAIL rst_drop_t%0d: got %h/%b want %h/0", i, sub1.rdt, sub1.err, 32'h0); n_fail++;
      end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_hold();
    test_back_to_back();
    test_error();
    test_stall();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
